// File: rtl/shift_seq.sv
// Iterative shift engine: one 1-bit LSL/LSR/ASR/ROR step per clock,
// start/busy/done handshake, carry-out and LSL overflow flags.
module shift_seq #(
  parameter int WIDTH = 32,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t          state;
  logic [1:0]      op_q;
  logic [AW-1:0]   count;
  logic [WIDTH-1:0] step_out;
  logic            step_c;
  logic            step_v;

  // Single-bit step applied to the running result.
  always_comb begin
    step_out = out;
    step_c   = 1'b0;
    step_v   = 1'b0;
    unique case (op_q)
      OP_LSL: begin
        step_out = {out[WIDTH-2:0], 1'b0};
        step_c   = out[WIDTH-1];
        step_v   = out[WIDTH-1] ^ out[WIDTH-2];
      end
      OP_LSR: begin
        step_out = {1'b0, out[WIDTH-1:1]};
        step_c   = out[0];
      end
      OP_ASR: begin
        step_out = {out[WIDTH-1], out[WIDTH-1:1]};
        step_c   = out[0];
      end
      OP_ROR: begin
        step_out = {out[0], out[WIDTH-1:1]};
        step_c   = out[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_LSL;
      count    <= '0;
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            out      <= in;
            cout     <= 1'b0;
            overflow <= 1'b0;
            op_q     <= op;
            if (amt == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              count <= amt;
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          out      <= step_out;
          cout     <= step_c;
          overflow <= overflow | step_v;
          count    <= count - 1'b1;
          if (count == 1) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
